// File: rtl/fcs_req_arbiter.sv
// rtl/fcs_req_arbiter.sv - round-robin arbiter sharing one serial CRC-16 FCS engine
module fcs_req_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_SIZE = 1024,
    parameter int MIN_SIZE = 64,
    parameter int SIZE_W   = $clog2(MAX_SIZE),
    parameter int REM_W    = 16,
    parameter int TIMEOUT  = 256
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [NUM_REQ*SIZE_W-1:0]  Req_Size,
    input  logic [NUM_REQ-1:0]         Req_Bit,
    output logic [NUM_REQ-1:0]         Grant,
    output logic                       Bit_Strobe,
    output logic [REM_W-1:0]           Fcs_Result,
    output logic                       Fcs_Valid,
    output logic                       Err,
    output logic                       Eng_Valid_Data,
    output logic [SIZE_W-1:0]          Eng_Data_Size,
    output logic                       Eng_Input_Data,
    input  logic                       Eng_OUT,
    input  logic                       Eng_Valid_OUT,
    input  logic                       Eng_Done,
    input  logic                       Eng_Busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CAP_W = $clog2(REM_W + 2);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_REJECT,
        S_LAUNCH,
        S_STREAM,
        S_COLLECT,
        S_DELIVER,
        S_ERROR,
        S_RELEASE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;
    logic [SIZE_W-1:0] sel_size;
    logic [SIZE_W-1:0] bit_cnt;
    logic [CAP_W-1:0]  cap_cnt;
    logic [CAP_W-1:0]  cap_nx;
    logic [WD_W-1:0]   wd_cnt;
    logic [REM_W-1:0]  sr;
    logic [REM_W-1:0]  sr_nx;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= NUM_REQ) ? IDX_W'(v - NUM_REQ) : IDX_W'(v);
    endfunction

    // Scan from the highest offset down so the nearest request after rr_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (Req[wrap_idx(int'(rr_ptr) + k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(int'(rr_ptr) + k);
            end
        end
        sel_size = Req_Size[int'(sel_idx)*SIZE_W +: SIZE_W];
    end

    // Capture path includes the bit arriving in the same cycle as Done.
    always_comb begin
        sr_nx  = sr;
        cap_nx = cap_cnt;
        if (Eng_Valid_OUT) begin
            sr_nx = {sr[REM_W-2:0], Eng_OUT};
            if (cap_cnt != CAP_W'(REM_W + 1)) begin
                cap_nx = cap_cnt + CAP_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if ((|Req) && !Eng_Busy) begin
                    state_nx = S_ARB;
                end
            end
            S_ARB: begin
                if (!sel_found) begin
                    state_nx = S_IDLE;
                end else if (sel_size < SIZE_W'(MIN_SIZE)) begin
                    state_nx = S_REJECT;
                end else begin
                    state_nx = S_LAUNCH;
                end
            end
            S_REJECT: state_nx = S_RELEASE;
            S_LAUNCH: begin
                state_nx = (Eng_Data_Size == SIZE_W'(1)) ? S_COLLECT : S_STREAM;
            end
            S_STREAM: begin
                if (bit_cnt == Eng_Data_Size - SIZE_W'(1)) begin
                    state_nx = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (Eng_Done) begin
                    state_nx = (cap_nx == CAP_W'(REM_W)) ? S_DELIVER : S_ERROR;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    state_nx = S_ERROR;
                end
            end
            S_DELIVER: state_nx = S_RELEASE;
            S_ERROR:   state_nx = S_RELEASE;
            S_RELEASE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        Bit_Strobe     = 1'b0;
        Eng_Valid_Data = 1'b0;
        Fcs_Valid      = 1'b0;
        Err            = 1'b0;
        case (state)
            S_LAUNCH: begin
                Bit_Strobe     = 1'b1;
                Eng_Valid_Data = 1'b1;
            end
            S_STREAM:  Bit_Strobe = 1'b1;
            S_DELIVER: Fcs_Valid  = 1'b1;
            S_REJECT:  Err        = 1'b1;
            S_ERROR:   Err        = 1'b1;
            default:   Bit_Strobe = 1'b0;
        endcase
        Eng_Input_Data = Bit_Strobe & Req_Bit[gnt_idx];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            Grant         <= '0;
            Eng_Data_Size <= '0;
            Fcs_Result    <= '0;
            bit_cnt       <= '0;
            cap_cnt       <= '0;
            wd_cnt        <= '0;
            sr            <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_ARB: begin
                    if (sel_found) begin
                        Grant   <= NUM_REQ'(1) << sel_idx;
                        gnt_idx <= sel_idx;
                        if (state_nx == S_LAUNCH) begin
                            Eng_Data_Size <= sel_size;
                        end
                    end
                end
                S_LAUNCH: begin
                    bit_cnt <= SIZE_W'(1);
                    cap_cnt <= '0;
                    wd_cnt  <= '0;
                    sr      <= '0;
                end
                S_STREAM: bit_cnt <= bit_cnt + SIZE_W'(1);
                S_COLLECT: begin
                    sr      <= sr_nx;
                    cap_cnt <= cap_nx;
                    wd_cnt  <= wd_cnt + WD_W'(1);
                    if (state_nx == S_DELIVER) begin
                        Fcs_Result <= sr_nx;
                    end
                end
                default: bit_cnt <= bit_cnt;
            endcase
            // Grant drops on entry to RELEASE; the pointer moves past the served requester.
            if (state_nx == S_RELEASE) begin
                Grant  <= '0;
                rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end
    end

endmodule
